// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit MIPS core.
// Owns the PC, drives the imem request/ready handshake, and presents bubbles as all-zero words.
module fetch_ifid_stage #(
  parameter int unsigned           PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_rdata,
  input  logic                imem_ready,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [15:0]         ifid_instr,
  output logic [2:0]          ifid_opcode,
  output logic [PC_WIDTH-1:0] ifid_pcplus2,
  output logic                ifid_valid
);

  typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pending_pc_q, pending_pc_d;
  logic [15:0]         instr_q, instr_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [PC_WIDTH-1:0] pcplus2_q, pcplus2_d;
  logic                valid_q, valid_d;

  logic [PC_WIDTH-1:0] redirect_tgt;
  logic [PC_WIDTH-1:0] pc_plus2;
  logic                ifid_bubble;
  logic                ifid_load;

  assign redirect_tgt = redirect_pc & ~PC_WIDTH'(1);
  assign pc_plus2     = pc_q + PC_WIDTH'(2);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    ifid_bubble  = 1'b0;
    ifid_load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d     = StFetch;
        ifid_bubble = 1'b1;
      end
      StFetch: begin
        if (redirect_valid) begin
          ifid_bubble = 1'b1;
          if (imem_ready) begin
            pc_d = redirect_tgt;
          end else begin
            // Request in flight: keep the address stable until the stale word drains.
            pending_pc_d = redirect_tgt;
            state_d      = StDiscard;
          end
        end else if (stall) begin
          ifid_bubble = 1'b0;
        end else if (imem_ready) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus2;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
      StDiscard: begin
        if (redirect_valid) begin
          pending_pc_d = redirect_tgt;
          ifid_bubble  = 1'b1;
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
        if (imem_ready) begin
          pc_d    = redirect_valid ? redirect_tgt : pending_pc_q;
          state_d = StFetch;
        end
      end
      default: begin
        state_d     = StIdle;
        ifid_bubble = 1'b1;
      end
    endcase

    instr_d   = instr_q;
    opcode_d  = opcode_q;
    pcplus2_d = pcplus2_q;
    valid_d   = valid_q;
    if (ifid_bubble) begin
      instr_d   = '0;
      opcode_d  = '0;
      pcplus2_d = '0;
      valid_d   = 1'b0;
    end else if (ifid_load) begin
      instr_d   = imem_rdata;
      opcode_d  = imem_rdata[15:13];
      pcplus2_d = pc_plus2;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      instr_q      <= '0;
      opcode_q     <= '0;
      pcplus2_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      instr_q      <= instr_d;
      opcode_q     <= opcode_d;
      pcplus2_q    <= pcplus2_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req     = (state_q != StIdle);
  assign imem_addr    = pc_q;
  assign ifid_instr   = instr_q;
  assign ifid_opcode  = opcode_q;
  assign ifid_pcplus2 = pcplus2_q;
  assign ifid_valid   = valid_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed vector table, reset corner cases, then random
// stimulus against a transaction-level model of the fetch stream.
module tb_fetch_ifid_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] ifid_instr;
  logic [2:0]  ifid_opcode;
  logic [15:0] ifid_pcplus2;
  logic        ifid_valid;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Memory contents: word at address a is 0x1000 + a.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_ifid_stage #(
    .PC_WIDTH (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_instr     (ifid_instr),
    .ifid_opcode    (ifid_opcode),
    .ifid_pcplus2   (ifid_pcplus2),
    .ifid_valid     (ifid_valid)
  );

  typedef struct {
    logic        stall;
    logic        ready;
    logic        rv;
    logic [15:0] rpc;
    logic [15:0] e_instr;
    logic [15:0] e_pcp2;
    logic        e_valid;
    logic [15:0] e_addr;
    logic        e_req;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic rv, input logic [15:0] rpc,
                     input logic [15:0] ei, input logic [15:0] ep, input logic ev,
                     input logic [15:0] ea, input logic er);
    vec_t v;
    v.stall = s; v.ready = r; v.rv = rv; v.rpc = rpc;
    v.e_instr = ei; v.e_pcp2 = ep; v.e_valid = ev; v.e_addr = ea; v.e_req = er;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                               input logic ev, input logic [15:0] ea, input logic er);
    logic [2:0] eop;
    eop = ei[15:13];
    chk({tag, ".instr"}, ifid_instr, ei);
    chk({tag, ".opcode"}, {13'd0, ifid_opcode}, {13'd0, eop});
    chk({tag, ".pcplus2"}, ifid_pcplus2, ep);
    chk({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, ev});
    chk({tag, ".addr"}, imem_addr, ea);
    chk({tag, ".req"}, {15'd0, imem_req}, {15'd0, er});
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i < last; i++) begin
      stall          = vecs[i].stall;
      imem_ready     = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(posedge clock);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pcp2, vecs[i].e_valid,
                    vecs[i].e_addr, vecs[i].e_req);
    end
  endtask

  // Reference model: a stream of fetch addresses, with an optional stale request that
  // must complete before the most recent redirect target is fetched.
  logic        m_started;
  logic        m_stale;
  logic [15:0] m_pc;
  logic [15:0] m_target;
  logic [15:0] m_instr;
  logic [15:0] m_pcp2;
  logic        m_valid;

  task automatic model_reset();
    m_started = 1'b0; m_stale = 1'b0; m_pc = 16'h0000; m_target = 16'h0000;
    m_instr = 16'h0; m_pcp2 = 16'h0; m_valid = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = 16'h0; m_pcp2 = 16'h0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic rv, input logic [15:0] rpc);
    logic [15:0] tgt;
    tgt = {rpc[15:1], 1'b0};
    if (!m_started) begin
      m_started = 1'b1;
      model_bubble();
    end else if (m_stale) begin
      if (rv) begin
        m_target = tgt;
        model_bubble();
      end else if (!s) begin
        model_bubble();
      end
      if (r) begin
        m_pc    = m_target;
        m_stale = 1'b0;
      end
    end else if (rv) begin
      model_bubble();
      if (r) m_pc = tgt;
      else begin
        m_stale  = 1'b1;
        m_target = tgt;
      end
    end else if (!s) begin
      if (r) begin
        m_instr = mem_word(m_pc);
        m_pcp2  = m_pc + 16'd2;
        m_valid = 1'b1;
        m_pc    = m_pc + 16'd2;
      end else begin
        model_bubble();
      end
    end
  endtask

  initial begin
    int n_a;
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    check_outputs("reset", 16'h0, 16'h0, 1'b0, 16'h0000, 1'b0);

    // Always-ready start, 3-cycle wait, 2-cycle stall, redirects, wrap.
    add(0, 1, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0000, 1);
    add(0, 1, 0, 16'h0,    16'h1000, 16'h0002, 1, 16'h0002, 1);
    add(0, 1, 0, 16'h0,    16'h1002, 16'h0004, 1, 16'h0004, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0004, 1);
    add(0, 1, 0, 16'h0,    16'h1004, 16'h0006, 1, 16'h0006, 1);
    for (int i = 0; i < 2; i++) add(1, 1, 0, 16'h0, 16'h1004, 16'h0006, 1, 16'h0006, 1);
    add(0, 1, 0, 16'h0,    16'h1006, 16'h0008, 1, 16'h0008, 1);
    add(0, 1, 0, 16'h0,    16'h1008, 16'h000A, 1, 16'h000A, 1);
    add(0, 1, 0, 16'h0,    16'h100A, 16'h000C, 1, 16'h000C, 1);
    add(0, 1, 1, 16'h0040, 16'h0,    16'h0,    0, 16'h0040, 1);
    add(0, 1, 0, 16'h0,    16'h1040, 16'h0042, 1, 16'h0042, 1);
    add(0, 1, 1, 16'h0010, 16'h0,    16'h0,    0, 16'h0010, 1);
    add(0, 0, 1, 16'h0040, 16'h0,    16'h0,    0, 16'h0010, 1);
    add(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0010, 1);
    add(0, 0, 1, 16'h0080, 16'h0,    16'h0,    0, 16'h0010, 1);
    add(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0010, 1);
    add(0, 1, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0080, 1);
    add(0, 1, 0, 16'h0,    16'h1080, 16'h0082, 1, 16'h0082, 1);
    add(0, 1, 1, 16'hFFFF, 16'h0,    16'h0,    0, 16'hFFFE, 1);
    add(0, 1, 0, 16'h0,    16'h0FFE, 16'h0000, 1, 16'h0000, 1);
    add(0, 1, 0, 16'h0,    16'h1000, 16'h0002, 1, 16'h0002, 1);
    add(0, 0, 1, 16'h0040, 16'h0,    16'h0,    0, 16'h0002, 1);
    n_a = vecs.size();
    // After a mid-DISCARD reset: fetch restarts at 0 and the old target is forgotten.
    add(0, 1, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0000, 1);
    add(0, 1, 0, 16'h0,    16'h1000, 16'h0002, 1, 16'h0002, 1);

    @(negedge clock);
    reset = 1'b0;
    run_vecs(0, n_a);

    // Asynchronous reset while in DISCARD, observed before the next edge.
    reset = 1'b1;
    #1;
    check_outputs("midreset", 16'h0, 16'h0, 1'b0, 16'h0000, 1'b0);
    #1;
    reset = 1'b0;
    run_vecs(n_a, vecs.size());

    // Random phase.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 99) < 20);
      imem_ready     = ($urandom_range(0, 99) < 65);
      redirect_valid = ($urandom_range(0, 99) < 10);
      redirect_pc    = $urandom_range(0, 16'hFFFF);
      model_step(stall, imem_ready, redirect_valid, redirect_pc);
      @(posedge clock);
      #1;
      check_outputs($sformatf("rnd%0d", c), m_instr, m_pcp2, m_valid, m_pc, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ifid_stage.md
# fetch_ifid_stage

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined MIPS core. It owns the PC and drives the instruction-memory request/ready handshake. It honours stall requests from hazard detection and redirects from branch/jump resolution. Its registered outputs (instruction, 3-bit opcode, PC+2, valid) feed the decode-stage control unit and register file directly. A bubble is always presented as an all-zero instruction, which the control unit decodes as a NOP.

## Interface

Parameters:
- PC_WIDTH, 16: width of PC, memory address and redirect target.
- RESET_PC, 16'h0000: PC value loaded on reset.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  fetch request; 0 only in IDLE.
- imem_addr  out  PC_WIDTH  fetch address; always equals PC register; stable while imem_req=1 and imem_ready=0.
- imem_rdata  in  16  instruction word; sampled only in a cycle with imem_req=1 and imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- stall  in  1  from hazard unit; hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump; flush IF/ID and retarget PC.
- redirect_pc  in  PC_WIDTH  redirect target, even-aligned.
- ifid_instr  out  16  registered instruction; 0 = bubble.
- ifid_opcode  out  3  registered, equals ifid_instr[15:13].
- ifid_pcplus2  out  PC_WIDTH  registered fetch address + 2; 0 for a bubble.
- ifid_valid  out  1  1 when IF/ID holds a real fetched instruction.

## Operation

- State registers:
  - state ∈ {IDLE, FETCH, DISCARD}.
  - pc.
  - pending_pc.
  - IF/ID fields: instr, opcode, pcplus2, valid.
- Bubble: instr=0, opcode=0, pcplus2=0, valid=0.
- **IDLE** (entered only by reset):
  - imem_req=0.
  - Next cycle: go to FETCH; IF/ID loads a bubble.
- **FETCH** (imem_req=1). Rules in priority order:
  1. redirect_valid=1:
     - IF/ID loads a bubble, regardless of stall.
     - If imem_ready=1: data dropped; pc<=redirect_pc; stay in FETCH.
     - If imem_ready=0: pending_pc<=redirect_pc; go to DISCARD; pc unchanged so the address stays stable.
  2. stall=1: IF/ID and pc hold. A word returned this cycle is dropped and the same address is refetched.
  3. imem_ready=1:
     - IF/ID loads {imem_rdata, imem_rdata[15:13], pc+2, valid=1}.
     - pc<=pc+2.
  4. imem_ready=0: IF/ID loads a bubble; pc holds.
- **DISCARD** (imem_req=1, imem_addr = stale pc):
  - redirect_valid=1: pending_pc<=redirect_pc (latest wins); IF/ID loads a bubble.
  - imem_ready=1: data dropped; pc<=pending_pc (or redirect_pc if redirect_valid is also 1); go to FETCH.
  - Otherwise IF/ID: hold if stall=1, else bubble.
  - The stale word is never written into IF/ID.
- Arithmetic:
  - pc+2 is modulo 2^PC_WIDTH; 0xFFFE wraps to 0x0000.
  - redirect_pc bit 0 is ignored (forced to 0).

## Timing

- Reset values:
  - state=IDLE, pc=RESET_PC, pending_pc=0.
  - imem_req=0, imem_addr=RESET_PC.
  - ifid_instr=0, ifid_opcode=0, ifid_pcplus2=0, ifid_valid=0.
- Latency, zero-wait memory:
  - First request at edge 1 after reset deassertion.
  - First valid IF/ID at edge 2.
  - Then one instruction per cycle.
- Redirect:
  - IF/ID is a bubble on the edge after redirect_valid.
  - With ready=1, imem_addr=redirect_pc on that same edge.
  - The target instruction appears in IF/ID one edge later.
- Each wait cycle (ready=0, no stall) inserts exactly one bubble. No instruction is skipped or duplicated.
- Reset asserted in any state, including mid-DISCARD: outputs take reset values immediately, without waiting for a clock edge. No pending redirect survives.

## Test plan

- Reset release, RESET_PC=0, always-ready memory with mem[a]=0x1000+a:
  - Edge 1: imem_req=1, addr=0x0000.
  - Edge 2: ifid_instr=0x1000, pcplus2=0x0002, valid=1.
  - Edge 3: ifid_instr=0x1002.
- Stall held 2 cycles while addr=0x0006:
  - IF/ID holds 0x1004 and addr holds 0x0006 for both cycles.
  - After release, the next three IF/ID values are 0x1006, 0x1008, 0x100A.
- imem_ready low 3 cycles at addr=0x0004:
  - Three consecutive bubbles (instr=0, valid=0); addr stays 0x0004.
  - Then ifid_instr=0x1004, pcplus2=0x0006.
- Redirect_valid with ready=1, redirect_pc=0x0040:
  - Next edge: IF/ID bubble, addr=0x0040.
  - Following edge: ifid_instr=0x1040, pcplus2=0x0042.
- Redirect to 0x0040 while ready=0 at addr=0x0010; a second redirect to 0x0080 two cycles later; ready=1 after 4 cycles:
  - Stale word 0x1010 is never seen in IF/ID.
  - addr moves 0x0010→0x0080.
  - The first valid instruction is 0x1080.
- Wrap and reset:
  - pc=0xFFFE fetch gives pcplus2=0x0000 and next addr=0x0000.
  - Reset pulsed mid-DISCARD gives all outputs at reset values before the next clock edge.
  - After reset, fetch restarts from RESET_PC.
